admm_iter_ctrl: RTL and testbench

//  Top-level ADMM iteration sequencer for the MPC solver. Runs the per-iteration

---
 rtl/admm_pkg.sv | 26 ++
 rtl/phase_handshake.sv | 47 ++++
 rtl/admm_iter_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_admm_iter_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/admm_pkg.sv
// Shared types and default sizes for the ADMM iteration sequencer and its
// phase handshake engine.
package admm_pkg;

  localparam int DATA_WIDTH_DEF     = 16;
  localparam int HORIZON_DEF        = 30;
  localparam int ITER_WIDTH_DEF     = 16;
  localparam int TIMEOUT_CYCLES_DEF = 65535;

  typedef enum logic [1:0] {
    PH_PRIMAL = 2'd0,
    PH_SLACK  = 2'd1,
    PH_DUAL   = 2'd2,
    PH_RESID  = 2'd3
  } phase_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_PH_REQ = 3'd2,
    ST_PH_REL = 3'd3,
    ST_CHECK  = 3'd4,
    ST_FINISH = 3'd5
  } ctrl_state_e;

endpackage

// File: rtl/phase_handshake.sv
// Shared req/rel engine for all four phase handshakes: decodes done edges for
// the active phase and runs the per-half watchdog.
module phase_handshake
  import admm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_en,
  input  logic rel_en,
  input  logic done_i,
  output logic done_seen_o,
  output logic released_o,
  output logic timeout_o
);

  localparam int             WDW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT_CYCLES);

  logic [WDW-1:0] wdog_q, wdog_d, wdog_inc;
  logic           active, advancing;

  // The watchdog restarts from zero on every req->rel and rel->req step, so
  // each half of a handshake gets the full budget.
  always_comb begin
    active      = req_en || rel_en;
    done_seen_o = req_en && done_i;
    released_o  = rel_en && !done_i;
    advancing   = done_seen_o || released_o;
    wdog_inc    = wdog_q + WDW'(1);
    timeout_o   = active && !advancing && (wdog_inc == WD_LIMIT);
    wdog_d      = '0;
    if (active && !advancing) begin
      wdog_d = wdog_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

endmodule

// File: rtl/admm_iter_ctrl.sv
// ADMM iteration sequencer: primal -> slack -> dual (-> residual) per iteration,
// stopping on convergence, iteration limit, abort or phase timeout.
module admm_iter_ctrl
  import admm_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int HORIZON        = HORIZON_DEF,
  parameter int ITER_WIDTH     = ITER_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [31:0]           cfg_horizon,
  input  logic [ITER_WIDTH-1:0] cfg_max_iter,
  input  logic [3:0]            cfg_check_every,
  input  logic [DATA_WIDTH-1:0] cfg_tol_pri,
  input  logic [DATA_WIDTH-1:0] cfg_tol_dual,
  output logic [31:0]           active_horizon,
  output logic                  primal_start,
  input  logic                  primal_done,
  output logic                  slack_start,
  input  logic                  slack_done,
  output logic                  dual_start,
  input  logic                  dual_done,
  output logic                  resid_start,
  input  logic                  resid_done,
  input  logic [DATA_WIDTH-1:0] pri_res,
  input  logic [DATA_WIDTH-1:0] dual_res,
  output logic                  busy,
  output logic                  done,
  output logic                  converged,
  output logic                  timeout_err,
  output logic [ITER_WIDTH-1:0] iter_count
);

  function automatic logic [31:0] clamp_horizon(input logic [31:0] h);
    if (h < 32'd2) return 32'd2;
    if (h > 32'(HORIZON)) return 32'(HORIZON);
    return h;
  endfunction

  function automatic logic [ITER_WIDTH-1:0] floor_one_iter(input logic [ITER_WIDTH-1:0] v);
    return (v == '0) ? ITER_WIDTH'(1) : v;
  endfunction

  function automatic logic [3:0] floor_one_chk(input logic [3:0] v);
    return (v == 4'd0) ? 4'd1 : v;
  endfunction

  ctrl_state_e           state_q, state_d;
  phase_e                phase_q, phase_d;
  logic [3:0]            start_vec_q, start_vec_d;
  logic                  start_arm_q;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  conv_q, conv_d, tmo_q, tmo_d, drain_q, drain_d;
  logic [ITER_WIDTH-1:0] iter_q, iter_d, max_iter_q, max_iter_d, iter_inc;
  logic [3:0]            chk_q, chk_d, check_every_q, check_every_d, chk_inc;
  logic [DATA_WIDTH-1:0] tol_pri_q, tol_pri_d, tol_dual_q, tol_dual_d;
  logic [DATA_WIDTH-1:0] pri_res_q, pri_res_d, dual_res_q, dual_res_d;
  logic [31:0]           horizon_q, horizon_d;
  logic [3:0]            done_vec;
  logic                  phase_done, resid_due, conv_now, abort_hit;
  logic                  hs_done_seen, hs_released, hs_timeout;

  assign done_vec   = {resid_done, dual_done, slack_done, primal_done};
  assign phase_done = done_vec[phase_q];
  assign iter_inc   = iter_q + ITER_WIDTH'(1);
  assign chk_inc    = chk_q + 4'd1;
  assign resid_due  = (chk_inc == check_every_q) || (iter_inc == max_iter_q);
  assign conv_now   = (pri_res_q <= tol_pri_q) && (dual_res_q <= tol_dual_q);
  assign abort_hit  = abort && (state_q != ST_IDLE) && (state_q != ST_FINISH);

  phase_handshake #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_hs (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_en     (state_q == ST_PH_REQ),
    .rel_en     (state_q == ST_PH_REL),
    .done_i     (phase_done),
    .done_seen_o(hs_done_seen),
    .released_o (hs_released),
    .timeout_o  (hs_timeout)
  );

  // start_arm_q resets high so a start held through reset must drop first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      phase_q       <= PH_PRIMAL;
      start_vec_q   <= '0;
      start_arm_q   <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      conv_q        <= 1'b0;
      tmo_q         <= 1'b0;
      drain_q       <= 1'b0;
      iter_q        <= '0;
      max_iter_q    <= '0;
      chk_q         <= '0;
      check_every_q <= '0;
      tol_pri_q     <= '0;
      tol_dual_q    <= '0;
      pri_res_q     <= '0;
      dual_res_q    <= '0;
      horizon_q     <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      start_vec_q   <= start_vec_d;
      start_arm_q   <= start;
      busy_q        <= busy_d;
      done_q        <= done_d;
      conv_q        <= conv_d;
      tmo_q         <= tmo_d;
      drain_q       <= drain_d;
      iter_q        <= iter_d;
      max_iter_q    <= max_iter_d;
      chk_q         <= chk_d;
      check_every_q <= check_every_d;
      tol_pri_q     <= tol_pri_d;
      tol_dual_q    <= tol_dual_d;
      pri_res_q     <= pri_res_d;
      dual_res_q    <= dual_res_d;
      horizon_q     <= horizon_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !start_arm_q) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        phase_d = PH_PRIMAL;
        state_d = abort ? ST_FINISH : ST_PH_REQ;
      end
      ST_PH_REQ: begin
        if (abort)             state_d = ST_FINISH;
        else if (hs_done_seen) state_d = ST_PH_REL;
        else if (hs_timeout)   state_d = ST_FINISH;
      end
      ST_PH_REL: begin
        if (abort) begin
          state_d = ST_FINISH;
        end else if (hs_released) begin
          state_d = ST_PH_REQ;
          unique case (phase_q)
            PH_PRIMAL: phase_d = PH_SLACK;
            PH_SLACK:  phase_d = PH_DUAL;
            PH_DUAL:   phase_d = resid_due ? PH_RESID : PH_PRIMAL;
            PH_RESID:  state_d = ST_CHECK;
            default:   phase_d = PH_PRIMAL;
          endcase
        end else if (hs_timeout) begin
          state_d = ST_FINISH;
        end
      end
      ST_CHECK: begin
        if (abort || conv_now || (iter_q >= max_iter_q)) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_PH_REQ;
          phase_d = PH_PRIMAL;
        end
      end
      ST_FINISH: begin
        if (done_q && !start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start_vec_d   = (state_d == ST_PH_REQ) ? (4'b0001 << phase_d) : 4'b0000;
    busy_d        = busy_q;
    done_d        = done_q;
    conv_d        = conv_q;
    tmo_d         = tmo_q;
    drain_d       = drain_q;
    iter_d        = iter_q;
    max_iter_d    = max_iter_q;
    chk_d         = chk_q;
    check_every_d = check_every_q;
    tol_pri_d     = tol_pri_q;
    tol_dual_d    = tol_dual_q;
    pri_res_d     = pri_res_q;
    dual_res_d    = dual_res_q;
    horizon_d     = horizon_q;

    if (state_q == ST_IDLE && state_d == ST_LATCH)     busy_d = 1'b1;
    if (state_q != ST_FINISH && state_d == ST_FINISH)  busy_d = 1'b0;

    if (state_q == ST_LATCH) begin
      horizon_d     = clamp_horizon(cfg_horizon);
      max_iter_d    = floor_one_iter(cfg_max_iter);
      check_every_d = floor_one_chk(cfg_check_every);
      tol_pri_d     = cfg_tol_pri;
      tol_dual_d    = cfg_tol_dual;
      iter_d        = '0;
      chk_d         = '0;
      conv_d        = 1'b0;
      tmo_d         = 1'b0;
      drain_d       = 1'b0;
    end

    // Abort overrides any done/timeout landing on the same edge; a phase
    // caught mid-handshake must still see its done fall before we report.
    if (abort_hit) begin
      conv_d  = 1'b0;
      tmo_d   = 1'b0;
      drain_d = (state_q == ST_PH_REQ) || (state_q == ST_PH_REL);
    end else begin
      unique case (state_q)
        ST_PH_REQ: begin
          if (hs_done_seen) begin
            if (phase_q == PH_RESID) begin
              pri_res_d  = pri_res;
              dual_res_d = dual_res;
            end
          end else if (hs_timeout) begin
            tmo_d = 1'b1;
          end
        end
        ST_PH_REL: begin
          if (hs_released) begin
            if (phase_q == PH_DUAL) begin
              iter_d = iter_inc;
              chk_d  = (chk_inc == check_every_q) ? 4'd0 : chk_inc;
            end
          end else if (hs_timeout) begin
            tmo_d = 1'b1;
          end
        end
        ST_CHECK: conv_d = conv_now;
        ST_FINISH: begin
          if (!done_q) begin
            if (!drain_q || !phase_done) begin
              done_d  = 1'b1;
              drain_d = 1'b0;
            end
          end else if (!start) begin
            done_d = 1'b0;
            conv_d = 1'b0;
            tmo_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    primal_start   = start_vec_q[0];
    slack_start    = start_vec_q[1];
    dual_start     = start_vec_q[2];
    resid_start    = start_vec_q[3];
    busy           = busy_q;
    done           = done_q;
    converged      = conv_q;
    timeout_err    = tmo_q;
    iter_count     = iter_q;
    active_horizon = horizon_q;
  end

endmodule

// File: tb/tb_admm_iter_ctrl.sv
// Randomized bench for admm_iter_ctrl: stub phase blocks with random latency,
// checked against an iteration-level reference model of the solve sequence.
module tb_admm_iter_ctrl;

  localparam int DW  = 16;
  localparam int IW  = 16;
  localparam int HZ  = 30;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [31:0]   cfg_horizon = '0;
  logic [IW-1:0] cfg_max_iter = '0;
  logic [3:0]    cfg_check_every = '0;
  logic [DW-1:0] cfg_tol_pri = '0;
  logic [DW-1:0] cfg_tol_dual = '0;
  logic [DW-1:0] pri_res = '0;
  logic [DW-1:0] dual_res = '0;
  logic [31:0]   active_horizon;
  logic          primal_start, slack_start, dual_start, resid_start;
  wire  [3:0]    done_v;
  logic          busy, done, converged, timeout_err;
  logic [IW-1:0] iter_count;
  logic [3:0]    start_v;

  int n_checks = 0;
  int n_errors = 0;
  bit stuck[4];
  bit hold[4];
  int res_pri[$];
  int res_dual[$];
  int ridx = 0;
  int exp_seq[$];
  int obs_seq[$];
  int onehot_viol = 0;
  int busy_viol = 0;

  assign start_v = {resid_start, dual_start, slack_start, primal_start};

  admm_iter_ctrl #(
    .DATA_WIDTH(DW), .HORIZON(HZ), .ITER_WIDTH(IW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_horizon(cfg_horizon), .cfg_max_iter(cfg_max_iter),
    .cfg_check_every(cfg_check_every), .cfg_tol_pri(cfg_tol_pri),
    .cfg_tol_dual(cfg_tol_dual), .active_horizon(active_horizon),
    .primal_start(primal_start), .primal_done(done_v[0]),
    .slack_start(slack_start), .slack_done(done_v[1]),
    .dual_start(dual_start), .dual_done(done_v[2]),
    .resid_start(resid_start), .resid_done(done_v[3]),
    .pri_res(pri_res), .dual_res(dual_res),
    .busy(busy), .done(done), .converged(converged),
    .timeout_err(timeout_err), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got 0, expected finish");
    $fatal(1, "bench watchdog expired");
  end

  // Stub phase blocks: raise done some cycles after start, drop it some
  // cycles after start falls; stuck never answers, hold never releases.
  for (genvar g = 0; g < 4; g++) begin : g_resp
    logic        d = 1'b0;
    int unsigned cnt = 0;
    int unsigned lat = 0;
    assign done_v[g] = d;
    initial forever begin
      @(negedge clk);
      if (!rst_n) begin
        d = 1'b0;
        cnt = 0;
      end else if (start_v[g] && !d && !stuck[g]) begin
        if (cnt >= lat) begin d = 1'b1; cnt = 0; lat = $urandom_range(3, 0); end
        else cnt++;
      end else if (!start_v[g] && d && !hold[g]) begin
        if (cnt >= lat) begin d = 1'b0; cnt = 0; lat = $urandom_range(3, 0); end
        else cnt++;
      end
    end
  end

  initial forever begin
    @(posedge resid_start);
    pri_res  = (ridx < res_pri.size())  ? DW'(res_pri[ridx])  : DW'(0);
    dual_res = (ridx < res_dual.size()) ? DW'(res_dual[ridx]) : DW'(0);
    ridx++;
  end

  initial begin
    logic [3:0] prev;
    prev = 4'b0000;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (start_v[i] && !prev[i]) obs_seq.push_back(i);
      end
      if ($countones(start_v) > 1) onehot_viol++;
      if (start_v != 4'b0000 && !busy) busy_viol++;
      prev = start_v;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_res(input int lo, input int hi);
    res_pri.delete();
    res_dual.delete();
    for (int i = 0; i < 16; i++) begin
      res_pri.push_back($urandom_range(hi, lo));
      res_dual.push_back($urandom_range(hi, lo));
    end
  endtask

  // Reference: each iteration runs primal, slack, dual; the residual phase
  // follows when the iteration number hits a check period or the limit.
  task automatic build_model(input int mi, input int ce, input int tp, input int td,
                             output int e_iter, output bit e_conv);
    int m, c, r;
    m = (mi == 0) ? 1 : mi;
    c = (ce == 0) ? 1 : ce;
    r = 0;
    e_iter = 0;
    e_conv = 1'b0;
    exp_seq.delete();
    for (int k = 1; k <= m; k++) begin
      exp_seq.push_back(0);
      exp_seq.push_back(1);
      exp_seq.push_back(2);
      e_iter = k;
      if ((k % c == 0) || (k == m)) begin
        exp_seq.push_back(3);
        e_conv = (res_pri[r] <= tp) && (res_dual[r] <= td);
        r++;
        if (e_conv) break;
      end
    end
  endtask

  task automatic set_cfg(input int h, input int mi, input int ce, input int tp, input int td);
    cfg_horizon     = 32'(h);
    cfg_max_iter    = IW'(mi);
    cfg_check_every = 4'(ce);
    cfg_tol_pri     = DW'(tp);
    cfg_tol_dual    = DW'(td);
  endtask

  task automatic wait_done(input int lim, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, done, 1);
  endtask

  task automatic end_solve(input string tag);
    int n;
    start = 1'b0;
    n = 0;
    while (done !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, done, 0);
    @(negedge clk);
  endtask

  task automatic do_solve(input int h, input int mi, input int ce, input int tp,
                          input int td, input string tag);
    int e_iter, eh, mism;
    bit e_conv;
    build_model(mi, ce, tp, td, e_iter, e_conv);
    eh = (h < 2) ? 2 : ((h > HZ) ? HZ : h);
    @(negedge clk);
    obs_seq.delete();
    ridx = 0;
    set_cfg(h, mi, ce, tp, td);
    start = 1'b1;
    @(negedge clk);
    check_eq({tag, "_busy_rise"}, busy, 1);
    wait_done(3000, {tag, "_done"});
    check_eq({tag, "_conv"}, converged, e_conv);
    check_eq({tag, "_iter"}, iter_count, e_iter);
    check_eq({tag, "_tmo"}, timeout_err, 0);
    check_eq({tag, "_horizon"}, active_horizon, eh);
    check_eq({tag, "_busy_fin"}, busy, 0);
    check_eq({tag, "_nstarts"}, obs_seq.size(), exp_seq.size());
    mism = 0;
    for (int i = 0; i < exp_seq.size() && i < obs_seq.size(); i++) begin
      if (obs_seq[i] != exp_seq[i]) mism++;
    end
    check_eq({tag, "_order"}, mism, 0);
    end_solve({tag, "_clear"});
  endtask

  initial begin
    int n, cnt;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_conv", converged, 0);
    check_eq("rst_tmo", timeout_err, 0);
    check_eq("rst_iter", iter_count, 0);
    check_eq("rst_horizon", active_horizon, 0);
    check_eq("rst_starts", start_v, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    fill_res(0, 0);
    do_solve(10, 3, 1, 0, 0, "nominal");
    fill_res(5, 5);
    do_solve(30, 4, 2, 0, 0, "noconv");
    fill_res(1, 9);
    do_solve(100, 0, 0, 0, 0, "clamp_hi");
    do_solve(0, 2, 0, 0, 0, "clamp_lo");

    for (int t = 0; t < 10; t++) begin
      fill_res(0, 10);
      do_solve($urandom_range(40, 0), $urandom_range(6, 0), $urandom_range(5, 0),
               $urandom_range(7, 0), $urandom_range(7, 0), $sformatf("rand%0d", t));
    end

    // Slack phase never answers: watchdog must end the solve.
    stuck[1] = 1'b1;
    fill_res(0, 0);
    @(negedge clk);
    set_cfg(10, 5, 1, 0, 0);
    start = 1'b1;
    n = 0;
    while (slack_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("tmo_slack_rise", slack_start, 1);
    cnt = 0;
    while (slack_start === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check_eq("tmo_start_width", cnt, TMO);
    wait_done(50, "tmo_done");
    check_eq("tmo_flag", timeout_err, 1);
    check_eq("tmo_conv", converged, 0);
    check_eq("tmo_iter", iter_count, 0);
    check_eq("tmo_busy", busy, 0);
    stuck[1] = 1'b0;
    end_solve("tmo_clear");

    // Abort on the same edge dual_done is seen, with dual_done held high.
    hold[2] = 1'b1;
    fill_res(0, 0);
    @(negedge clk);
    set_cfg(8, 5, 1, 0, 0);
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(dual_start === 1'b1 && done_v[2] === 1'b1) && n < 300);
    check_eq("abort_window", dual_start & done_v[2], 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_drop", dual_start, 0);
    repeat (4) @(negedge clk);
    check_eq("abort_drain_done", done, 0);
    check_eq("abort_drain_busy", busy, 0);
    check_eq("abort_drain_starts", start_v, 0);
    hold[2] = 1'b0;
    wait_done(50, "abort_done");
    check_eq("abort_conv", converged, 0);
    check_eq("abort_tmo", timeout_err, 0);
    check_eq("abort_iter", iter_count, 0);
    end_solve("abort_clear");

    // Asynchronous reset mid-phase, then start held high across release.
    fill_res(0, 0);
    @(negedge clk);
    set_cfg(12, 5, 1, 0, 0);
    start = 1'b1;
    n = 0;
    while (primal_start !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_mid_primal_up", primal_start, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_starts", start_v, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_done", done, 0);
    check_eq("rst_mid_horizon", active_horizon, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("rst_no_retrigger_busy", busy, 0);
    check_eq("rst_no_retrigger_starts", start_v, 0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 5) begin
      @(negedge clk);
      n++;
    end
    check_eq("rearm_busy", busy, 1);
    wait_done(3000, "rearm_done");
    check_eq("rearm_conv", converged, 1);
    check_eq("rearm_iter", iter_count, 1);
    end_solve("rearm_clear");

    check_eq("onehot_starts", onehot_viol, 0);
    check_eq("busy_during_starts", busy_viol, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
